// File: rtl/rx_data_controller.sv
// Receive-side Aurora framing controller: strips SCP/ECP/idle symbols and rebuilds
// an AXI-stream (valid/last/data) by holding one word so last lands on the final word.
`ifndef AXI_DATA_SIZE
`define AXI_DATA_SIZE 32
`endif

package aurora_pkg;
    typedef enum logic [1:0] {
        NONE = 2'd0,
        I    = 2'd1,
        SCP  = 2'd2,
        ECP  = 2'd3
    } ordered_sets_e;
endpackage

module rx_data_controller
    import aurora_pkg::*;
#(
    parameter int SOF_LEN = 2,
    parameter int EOF_LEN = 2,
    parameter int LEN_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      lane_up,
    input  ordered_sets_e             rx_ordered_sets,
    input  logic [`AXI_DATA_SIZE-1:0] rx_data,
    output logic                      m_axi_valid,
    output logic                      m_axi_last,
    output logic [`AXI_DATA_SIZE-1:0] m_axi_data,
    output logic                      frame_err,
    output logic [LEN_W-1:0]          frame_len,
    output logic [1:0]                dbg_state_o
);

    localparam int DW    = `AXI_DATA_SIZE;
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] SOF_TGT = CNT_W'(SOF_LEN);
    localparam logic [CNT_W-1:0] EOF_TGT = CNT_W'(EOF_LEN);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SOF    = 2'd1,
        ST_STREAM = 2'd2,
        ST_EOF    = 2'd3
    } state_e;

    // A one-symbol start (or end) sequence skips the SOF (or EOF) counting state.
    localparam state_e OPEN_ST  = (SOF_LEN <= 1) ? ST_STREAM : ST_SOF;
    localparam state_e CLOSE_ST = (EOF_LEN <= 1) ? ST_IDLE   : ST_EOF;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  sof_cnt_q, sof_cnt_d;
    logic [CNT_W-1:0]  eof_cnt_q, eof_cnt_d;
    logic [LEN_W-1:0]  wcnt_q, wcnt_d;
    logic [DW-1:0]     hold_q, hold_d;
    logic              hold_valid_q, hold_valid_d;

    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic [DW-1:0]     data_q, data_d;
    logic              err_q, err_d;
    logic [LEN_W-1:0]  len_q, len_d;

    logic [CNT_W-1:0]  sof_nxt;
    logic [CNT_W-1:0]  eof_nxt;

    function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign sof_nxt = sof_cnt_q + 1'b1;
    assign eof_nxt = eof_cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            sof_cnt_q    <= '0;
            eof_cnt_q    <= '0;
            wcnt_q       <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            valid_q      <= 1'b0;
            last_q       <= 1'b0;
            data_q       <= '0;
            err_q        <= 1'b0;
            len_q        <= '0;
        end else begin
            state_q      <= state_d;
            sof_cnt_q    <= sof_cnt_d;
            eof_cnt_q    <= eof_cnt_d;
            wcnt_q       <= wcnt_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            valid_q      <= valid_d;
            last_q       <= last_d;
            data_q       <= data_d;
            err_q        <= err_d;
            len_q        <= len_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sof_cnt_d    = sof_cnt_q;
        eof_cnt_d    = eof_cnt_q;
        wcnt_d       = wcnt_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        if (!lane_up) begin
            state_d      = ST_IDLE;
            hold_valid_d = 1'b0;
            sof_cnt_d    = '0;
            eof_cnt_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_ordered_sets == SCP) begin
                        state_d   = OPEN_ST;
                        sof_cnt_d = CNT_W'(1);
                        wcnt_d    = '0;
                    end
                end
                ST_SOF: begin
                    if (rx_ordered_sets == SCP) begin
                        sof_cnt_d = sof_nxt;
                        if (sof_nxt >= SOF_TGT) begin
                            state_d = ST_STREAM;
                            wcnt_d  = '0;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_STREAM: begin
                    case (rx_ordered_sets)
                        NONE: begin
                            hold_d       = rx_data;
                            hold_valid_d = 1'b1;
                            if (hold_valid_q) wcnt_d = sat_inc(wcnt_q);
                        end
                        ECP: begin
                            hold_valid_d = 1'b0;
                            state_d      = CLOSE_ST;
                            eof_cnt_d    = CNT_W'(1);
                        end
                        // A restart mid-frame drops the held partial word.
                        SCP: begin
                            hold_valid_d = 1'b0;
                            state_d      = OPEN_ST;
                            sof_cnt_d    = CNT_W'(1);
                            wcnt_d       = '0;
                        end
                        default: ;
                    endcase
                end
                ST_EOF: begin
                    if (rx_ordered_sets == ECP) begin
                        eof_cnt_d = eof_nxt;
                        if (eof_nxt >= EOF_TGT) state_d = ST_IDLE;
                    end else if (rx_ordered_sets == SCP) begin
                        state_d   = OPEN_ST;
                        sof_cnt_d = CNT_W'(1);
                        wcnt_d    = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        valid_d = 1'b0;
        last_d  = 1'b0;
        data_d  = '0;
        err_d   = 1'b0;
        len_d   = len_q;
        if (!lane_up) begin
            err_d = (state_q == ST_SOF) || (state_q == ST_STREAM);
        end else begin
            case (state_q)
                ST_IDLE:   err_d = (rx_ordered_sets == ECP);
                ST_SOF:    err_d = (rx_ordered_sets != SCP);
                ST_STREAM: begin
                    case (rx_ordered_sets)
                        NONE: begin
                            if (hold_valid_q) begin
                                valid_d = 1'b1;
                                data_d  = hold_q;
                            end
                        end
                        ECP: begin
                            if (hold_valid_q) begin
                                valid_d = 1'b1;
                                last_d  = 1'b1;
                                data_d  = hold_q;
                                len_d   = sat_inc(wcnt_q);
                            end else begin
                                len_d = '0;
                            end
                        end
                        SCP:     err_d = 1'b1;
                        default: ;
                    endcase
                end
                ST_EOF:    err_d = (rx_ordered_sets != ECP);
                default:   ;
            endcase
        end
    end

    assign m_axi_valid = valid_q;
    assign m_axi_last  = last_q;
    assign m_axi_data  = data_q;
    assign frame_err   = err_q;
    assign frame_len   = len_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rx_data_controller.sv
// Directed bench for rx_data_controller: expected words queued as stimulus is driven,
// popped by per-instance monitors; a LEN_W=4 instance covers frame_len saturation.
`ifndef AXI_DATA_SIZE
`define AXI_DATA_SIZE 32
`endif

module tb_rx_data_controller;
  import aurora_pkg::*;

  localparam int DW = `AXI_DATA_SIZE;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          lane_up;
  ordered_sets_e rx_os;
  logic [DW-1:0] rx_data;

  logic          m_valid, m_last, f_err;
  logic [DW-1:0] m_data;
  logic [15:0]   f_len;
  logic [1:0]    dbg_state;

  logic          s_valid, s_last, s_err;
  logic [DW-1:0] s_data;
  logic [3:0]    s_len;
  logic [1:0]    s_dbg_state;

  int checks = 0;
  int passed = 0;
  int err_seen = 0;
  int err_sat_seen = 0;
  bit mon_en = 1'b0;

  logic [DW:0] exp_q[$];
  logic [DW:0] exp_sat_q[$];

  rx_data_controller #(.SOF_LEN(2), .EOF_LEN(2), .LEN_W(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .lane_up         (lane_up),
    .rx_ordered_sets (rx_os),
    .rx_data         (rx_data),
    .m_axi_valid     (m_valid),
    .m_axi_last      (m_last),
    .m_axi_data      (m_data),
    .frame_err       (f_err),
    .frame_len       (f_len),
    .dbg_state_o     (dbg_state)
  );

  rx_data_controller #(.SOF_LEN(2), .EOF_LEN(2), .LEN_W(4)) dut_sat (
    .clk             (clk),
    .rst_n           (rst_n),
    .lane_up         (lane_up),
    .rx_ordered_sets (rx_os),
    .rx_data         (rx_data),
    .m_axi_valid     (s_valid),
    .m_axi_last      (s_last),
    .m_axi_data      (s_data),
    .frame_err       (s_err),
    .frame_len       (s_len),
    .dbg_state_o     (s_dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks=%0d passed=%0d", checks, passed);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // driver tasks: inputs change on the falling edge
  task automatic sym(input ordered_sets_e s);
    @(negedge clk);
    rx_os   = s;
    rx_data = DW'($urandom);
  endtask

  task automatic word(input logic [DW-1:0] d);
    @(negedge clk);
    rx_os   = NONE;
    rx_data = d;
  endtask

  task automatic expect_word(input logic [DW-1:0] d, input logic last);
    exp_q.push_back({last, d});
    exp_sat_q.push_back({last, d});
  endtask

  task automatic idles(input int n);
    for (int k = 0; k < n; k++) sym(I);
  endtask

  // scoreboard monitors
  always @(negedge clk) begin
    logic [DW:0] e;
    if (mon_en) begin
      if (m_valid) begin
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = 'x;
        check("dut_word", 64'({m_last, m_data}), 64'(e));
      end else begin
        check("dut_quiet", 64'({m_last, m_data}), 64'd0);
      end
      if (f_err) err_seen++;
      if (s_valid) begin
        if (exp_sat_q.size() > 0) e = exp_sat_q.pop_front();
        else e = 'x;
        check("sat_word", 64'({s_last, s_data}), 64'(e));
      end
      if (s_err) err_sat_seen++;
    end
  end

  initial begin
    rst_n   = 1'b0;
    lane_up = 1'b1;
    rx_os   = I;
    rx_data = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(m_valid), 64'd0);
    check("rst_last", 64'(m_last), 64'd0);
    check("rst_data", 64'(m_data), 64'd0);
    check("rst_err", 64'(f_err), 64'd0);
    check("rst_len", 64'(f_len), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    check("rst_sat_len", 64'(s_len), 64'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // basic frame
    expect_word(32'hA1, 1'b0);
    expect_word(32'hA2, 1'b0);
    expect_word(32'hA3, 1'b1);
    sym(I); sym(SCP); sym(SCP);
    word(32'hA1); word(32'hA2); word(32'hA3);
    sym(ECP);
    sym(ECP);
    check("basic_last_latency", 64'({m_valid, m_last, m_data}), 64'({1'b1, 1'b1, 32'hA3}));
    sym(I);
    check("basic_len", 64'(f_len), 64'd3);
    idles(2);
    check("basic_no_err", 64'(err_seen), 64'd0);

    // gapped stream
    expect_word(32'h10, 1'b0);
    expect_word(32'h20, 1'b1);
    sym(SCP); sym(SCP);
    word(32'h10); sym(I); sym(I);
    check("gap_no_early_emit", 64'(m_valid), 64'd0);
    word(32'h20);
    sym(ECP);
    check("gap_first_word", 64'({m_valid, m_last, m_data}), 64'({1'b1, 1'b0, 32'h10}));
    sym(ECP);
    check("gap_last_word", 64'({m_valid, m_last, m_data}), 64'({1'b1, 1'b1, 32'h20}));
    sym(I);
    check("gap_len", 64'(f_len), 64'd2);

    // empty frame then back-to-back frame
    expect_word(32'h55, 1'b1);
    sym(SCP); sym(SCP); sym(ECP); sym(ECP);
    check("empty_len", 64'(f_len), 64'd0);
    check("empty_no_valid", 64'(m_valid), 64'd0);
    sym(SCP); sym(SCP);
    word(32'h55);
    sym(ECP); sym(ECP);
    sym(I);
    check("b2b_len", 64'(f_len), 64'd1);
    idles(2);
    check("b2b_no_err", 64'(err_seen), 64'd0);

    // single SCP then idle
    sym(SCP); sym(I); idles(3);
    check("short_sof_err", 64'(err_seen), 64'd1);
    check("short_sof_idle", 64'(dbg_state), 64'd0);

    // restart while holding 0x77: 0x77 must never appear
    expect_word(32'h78, 1'b1);
    sym(SCP); sym(SCP);
    word(32'h77);
    sym(SCP); sym(SCP);
    word(32'h78);
    sym(ECP); sym(ECP);
    idles(3);
    check("restart_err", 64'(err_seen), 64'd2);
    check("restart_len", 64'(f_len), 64'd1);

    // lone ECP in IDLE
    sym(ECP); idles(3);
    check("lone_ecp_err", 64'(err_seen), 64'd3);

    // lane drop mid-stream with a word held
    sym(SCP); sym(SCP);
    word(32'h99);
    @(negedge clk);
    lane_up = 1'b0;
    rx_os   = NONE;
    rx_data = 32'h9A;
    @(negedge clk);
    rx_os   = I;
    @(negedge clk);
    check("abort_idle", 64'(dbg_state), 64'd0);
    lane_up = 1'b1;
    idles(2);
    check("abort_err_once", 64'(err_seen), 64'd4);
    expect_word(32'h01, 1'b1);
    sym(SCP); sym(SCP);
    word(32'h01);
    sym(ECP); sym(ECP);
    check("abort_recover", 64'({m_valid, m_last, m_data}), 64'({1'b1, 1'b1, 32'h01}));
    idles(2);

    // synchronous reset mid-frame, held word discarded
    sym(SCP); sym(SCP);
    word(32'hB1);
    @(negedge clk);
    rst_n   = 1'b0;
    rx_os   = NONE;
    rx_data = 32'hB2;
    @(negedge clk);
    rst_n   = 1'b1;
    rx_os   = I;
    check("midrst_valid", 64'(m_valid), 64'd0);
    check("midrst_data", 64'(m_data), 64'd0);
    check("midrst_len", 64'(f_len), 64'd0);
    check("midrst_err", 64'(f_err), 64'd0);
    check("midrst_state", 64'(dbg_state), 64'd0);
    idles(3);

    // 20-word frame: LEN_W=4 instance saturates at 15
    for (int k = 0; k < 20; k++) expect_word(DW'(32'h100 + k), (k == 19));
    sym(SCP); sym(SCP);
    for (int k = 0; k < 20; k++) word(DW'(32'h100 + k));
    sym(ECP); sym(ECP);
    sym(I);
    check("sat_len_wide", 64'(f_len), 64'd20);
    check("sat_len_narrow", 64'(s_len), 64'd15);

    idles(4);
    check("dut_queue_drained", 64'(exp_q.size()), 64'd0);
    check("sat_queue_drained", 64'(exp_sat_q.size()), 64'd0);
    check("final_err_count", 64'(err_seen), 64'd4);
    check("final_sat_err_count", 64'(err_sat_seen), 64'd4);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/rx_data_controller.md
Name: rx_data_controller

Overview:
- Receive-side framing controller for the Aurora link.
- Consumes the per-cycle ordered-set classification (ordered_sets_e from aurora_pkg) and the data word recovered by the lane decoder.
- Strips the SCP/ECP framing and I idles, and rebuilds an AXI-stream master output with valid/last/data.
- Holds one word so that last can be attached to the final word of each frame, and flags framing violations.

Parameters:
- SOF_LEN, 2: number of consecutive SCP cycles that open a frame.
- EOF_LEN, 2: number of consecutive ECP cycles that close a frame.
- LEN_W, 16: width of the frame word counter.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- lane_up  input  1  link ready; low forces abort to IDLE
- rx_ordered_sets  input  ordered_sets_e  per-cycle symbol class: NONE = data word, I = idle, SCP = start, ECP = end
- rx_data  input  `AXI_DATA_SIZE  data word; qualified only when rx_ordered_sets == NONE
- m_axi_valid  output  1  output word valid, single-cycle per word, no backpressure
- m_axi_last  output  1  marks the final word of a frame; only meaningful with valid
- m_axi_data  output  `AXI_DATA_SIZE  output word; '0 when valid is low
- frame_err  output  1  one-cycle pulse on a framing violation
- frame_len  output  LEN_W  words in the last completed frame; saturates at all-ones

Behaviour:
- Reset: rst_n is synchronous and active-low; clock is clk. All outputs, the hold register, the hold_valid flag and all counters clear to 0. State is IDLE. Reset mid-frame discards any held word without emitting it.
- All outputs are registered. Decisions made in cycle N appear at the outputs in cycle N+1.
- IDLE:
  - SCP: go to SOF, sof_cnt = 1. If SOF_LEN == 1, go directly to STREAM.
  - ECP: frame_err.
  - NONE, I: ignored.
- SOF:
  - SCP: increment sof_cnt; on reaching SOF_LEN go to STREAM and clear the word counter.
  - Any other symbol: frame_err, go to IDLE.
- STREAM:
  - NONE: capture rx_data into hold and set hold_valid. If hold_valid was already set, emit the old hold word with valid=1, last=0, and increment the word counter. Capture and emit happen in the same cycle.
  - I: gap. No capture, no output.
  - ECP: if hold_valid, emit the hold word with valid=1, last=1, clear hold_valid, and latch frame_len = word counter + 1. If not hold_valid (empty frame), emit nothing and set frame_len = 0. Go to EOF with eof_cnt = 1, or go to IDLE if EOF_LEN == 1.
  - SCP: frame_err. Discard the held word; a partial frame never gets last. Go to SOF with sof_cnt = 1.
- EOF:
  - ECP: increment eof_cnt; on reaching EOF_LEN go to IDLE.
  - Any other symbol: frame_err, then handle the symbol as in IDLE in the same cycle (SCP → SOF).
- Back-to-back frames (ECP ECP SCP SCP) are accepted with no idle in between.
- Word counter arithmetic is LEN_W unsigned and saturates at all-ones.
- lane_up low in any state: go to IDLE and discard the hold. Pulse frame_err if the state was SOF or STREAM. No output is produced while lane_up is low.
- frame_err is a single pulse per violation. m_axi_valid never asserts outside STREAM-derived emits.
- Latency:
  - Non-final word: emitted 1 cycle after the next NONE word arrives.
  - Final word: emitted 1 cycle after the first ECP.

Test Plan:
- Basic frame. Stimulus: I, SCP, SCP, NONE(0xA1), NONE(0xA2), NONE(0xA3), ECP, ECP, I. Required: valid pulses carrying A1, A2 (last=0), then A3 (last=1) on the cycle after the first ECP; frame_len = 3; frame_err never asserts.
- Gapped stream. Stimulus: SCP, SCP, NONE(0x10), I, I, NONE(0x20), ECP, ECP. Required: 0x10 emitted the cycle after 0x20 arrives with last=0; 0x20 emitted with last=1; frame_len = 2.
- Empty frame and back-to-back. Stimulus: SCP, SCP, ECP, ECP, SCP, SCP, NONE(0x55), ECP, ECP. Required: no output for the first frame (frame_len = 0), then 0x55 with last=1 (frame_len = 1); no frame_err.
- Violations:
  - Single SCP followed by I: frame_err pulse, state returns to IDLE.
  - SCP in STREAM holding 0x77: 0x77 is never emitted, frame_err pulses, and the new frame proceeds normally.
  - Lone ECP in IDLE: frame_err pulse.
- Abort. Stimulus: lane_up dropped mid-STREAM with a word held. Required: no emit, frame_err pulses once. After lane_up returns, a clean SCP SCP NONE(0x01) ECP ECP produces 0x01 with last=1.
- Reset and saturation:
  - rst_n low for 1 cycle mid-frame: all outputs read 0 on the next cycle.
  - LEN_W = 4 with a 20-word frame: frame_len = 15 and all 20 words are delivered.
